// File: rtl/cellrv32_xbus_arbiter.sv
// rtl/cellrv32_xbus_arbiter.sv - two-port arbiter sharing the external bus gateway (policy macro: CELLRV32_XBUS_RR_EN)
// Port A = CPU data path, port B = CPU instruction fetch.
// Requests are captured into per-port pending entries, granted one at a time,
// issued as registered one-cycle strobes, and the gateway response is routed
// back to the owner of the grant. With CELLRV32_XBUS_RR_EN defined a
// simultaneous request pair is resolved round-robin, otherwise port A wins.

module cellrv32_xbus_arbiter (
   input  logic        clk_i,
   input  logic        rstn_i,
   // port A (data access)
   input  logic [31:0] a_addr_i,
   input  logic        a_rden_i,
   input  logic        a_wren_i,
   input  logic [3:0]  a_ben_i,
   input  logic [31:0] a_wdata_i,
   input  logic        a_priv_i,
   output logic [31:0] a_rdata_o,
   output logic        a_ack_o,
   output logic        a_err_o,
   output logic        a_tmo_o,
   // port B (instruction fetch)
   input  logic [31:0] b_addr_i,
   input  logic        b_rden_i,
   input  logic        b_wren_i,
   input  logic [3:0]  b_ben_i,
   input  logic [31:0] b_wdata_i,
   input  logic        b_priv_i,
   output logic [31:0] b_rdata_o,
   output logic        b_ack_o,
   output logic        b_err_o,
   output logic        b_tmo_o,
   // gateway side
   output logic        dev_src_o,
   output logic [31:0] dev_addr_o,
   output logic        dev_rden_o,
   output logic        dev_wren_o,
   output logic [3:0]  dev_ben_o,
   output logic [31:0] dev_wdata_o,
   output logic        dev_priv_o,
   input  logic [31:0] dev_rdata_i,
   input  logic        dev_ack_i,
   input  logic        dev_err_i,
   input  logic        dev_tmo_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t     state;
   logic       g;        // current grant: 0 = A, 1 = B
   logic [1:0] a_pend;   // [1] valid, [0] write
   logic [1:0] b_pend;

   // a pulse arriving this cycle counts as a request; wren wins over rden
   logic a_req_new, b_req_new;
   logic a_cand, b_cand;
   logic a_op, b_op;
   logic sel_b;
   logic win_wr;
   logic grant;
   logic busy;
   logic resp;

   assign a_req_new = a_rden_i | a_wren_i;
   assign b_req_new = b_rden_i | b_wren_i;
   assign a_cand    = a_pend[1] | a_req_new;
   assign b_cand    = b_pend[1] | b_req_new;
   assign a_op      = a_req_new ? a_wren_i : a_pend[0];
   assign b_op      = b_req_new ? b_wren_i : b_pend[0];

`ifdef CELLRV32_XBUS_RR_EN
   logic last;   // port granted most recently
   // on a tie the port that did not win last time goes next
   assign sel_b = b_cand & (~a_cand | ~last);
`else
   assign sel_b = b_cand & ~a_cand;
`endif

   assign win_wr = sel_b ? b_op : a_op;
   assign grant  = (state == S_IDLE) & (a_cand | b_cand);
   assign busy   = (state != S_IDLE);
   assign resp   = dev_ack_i | dev_err_i | dev_tmo_i;

   // arbitration FSM, pending capture and registered gateway strobes
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= S_IDLE;
         g          <= 1'b0;
         a_pend     <= 2'b00;
         b_pend     <= 2'b00;
         dev_rden_o <= 1'b0;
         dev_wren_o <= 1'b0;
`ifdef CELLRV32_XBUS_RR_EN
         last       <= 1'b1;
`endif
      end else begin
         dev_rden_o <= 1'b0;
         dev_wren_o <= 1'b0;
         if (a_req_new) a_pend <= {1'b1, a_wren_i};
         if (b_req_new) b_pend <= {1'b1, b_wren_i};
         case (state)
            S_IDLE: begin
               if (grant) begin
                  g          <= sel_b;
                  state      <= S_REQ;
                  dev_rden_o <= ~win_wr;
                  dev_wren_o <= win_wr;
                  // the winner's request is consumed by this grant
                  if (sel_b) b_pend <= 2'b00;
                  else       a_pend <= 2'b00;
`ifdef CELLRV32_XBUS_RR_EN
                  last       <= sel_b;
`endif
               end
            end
            S_REQ:   state <= resp ? S_IDLE : S_WAIT;
            S_WAIT:  if (resp) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign dev_src_o   = g;
   assign dev_addr_o  = g ? b_addr_i  : a_addr_i;
   assign dev_ben_o   = g ? b_ben_i   : a_ben_i;
   assign dev_wdata_o = g ? b_wdata_i : a_wdata_i;
   assign dev_priv_o  = g ? b_priv_i  : a_priv_i;

   assign a_ack_o   = ~g & busy & dev_ack_i;
   assign a_err_o   = ~g & busy & dev_err_i;
   assign a_tmo_o   = ~g & busy & dev_tmo_i;
   assign b_ack_o   =  g & busy & dev_ack_i;
   assign b_err_o   =  g & busy & dev_err_i;
   assign b_tmo_o   =  g & busy & dev_tmo_i;
   assign a_rdata_o = g ? 32'h0 : dev_rdata_i;
   assign b_rdata_o = g ? dev_rdata_i : 32'h0;

endmodule

// File: tb/tb_cellrv32_xbus_arbiter.sv
// tb/tb_cellrv32_xbus_arbiter.sv - self-checking bench for cellrv32_xbus_arbiter
module tb_cellrv32_xbus_arbiter;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0, dev_rdata = '0;
   logic        a_rden = 1'b0, a_wren = 1'b0, b_rden = 1'b0, b_wren = 1'b0;
   logic [3:0]  a_ben = '0, b_ben = '0;
   logic        a_priv = 1'b0, b_priv = 1'b0;
   logic        dev_ack = 1'b0, dev_err = 1'b0, dev_tmo = 1'b0;
   logic [31:0] a_rdata, b_rdata, dev_addr, dev_wdata;
   logic        a_ack, a_err, a_tmo, b_ack, b_err, b_tmo;
   logic        dev_src, dev_rden, dev_wren, dev_priv;
   logic [3:0]  dev_ben;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cellrv32_xbus_arbiter dut (
      .clk_i(clk), .rstn_i(rstn),
      .a_addr_i(a_addr), .a_rden_i(a_rden), .a_wren_i(a_wren), .a_ben_i(a_ben),
      .a_wdata_i(a_wdata), .a_priv_i(a_priv), .a_rdata_o(a_rdata),
      .a_ack_o(a_ack), .a_err_o(a_err), .a_tmo_o(a_tmo),
      .b_addr_i(b_addr), .b_rden_i(b_rden), .b_wren_i(b_wren), .b_ben_i(b_ben),
      .b_wdata_i(b_wdata), .b_priv_i(b_priv), .b_rdata_o(b_rdata),
      .b_ack_o(b_ack), .b_err_o(b_err), .b_tmo_o(b_tmo),
      .dev_src_o(dev_src), .dev_addr_o(dev_addr), .dev_rden_o(dev_rden),
      .dev_wren_o(dev_wren), .dev_ben_o(dev_ben), .dev_wdata_o(dev_wdata),
      .dev_priv_o(dev_priv), .dev_rdata_i(dev_rdata),
      .dev_ack_i(dev_ack), .dev_err_i(dev_err), .dev_tmo_i(dev_tmo)
   );

   // Reference model: who owns the gateway, who is waiting, whose strobe is due
   int  m_owner = -1;      // -1 = nobody, else port index
   bit  m_g = 1'b0;        // port the muxes point at
   int  m_last = 1;
   int  m_strobe = -1;     // port whose strobe is expected this cycle
   bit  m_strobe_wr = 1'b0;
   bit  m_wait [2];
   bit  m_wop  [2];
   bit  m_req  [2];
   bit  m_wr   [2];
   bit  m_both;
   int  m_w;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_owner = -1; m_g = 1'b0; m_last = 1; m_strobe = -1;
         m_wait[0] = 1'b0; m_wait[1] = 1'b0;
      end else begin
         m_req[0] = a_rden | a_wren;  m_wr[0] = a_wren;
         m_req[1] = b_rden | b_wren;  m_wr[1] = b_wren;
         m_strobe = -1;
         if (m_owner < 0) begin
            if (m_wait[0] | m_req[0] | m_wait[1] | m_req[1]) begin
               m_both = (m_wait[0] | m_req[0]) & (m_wait[1] | m_req[1]);
`ifdef CELLRV32_XBUS_RR_EN
               if (m_both) m_w = (m_last == 1) ? 0 : 1;
               else        m_w = (m_wait[0] | m_req[0]) ? 0 : 1;
`else
               m_w = (m_wait[0] | m_req[0]) ? 0 : 1;
`endif
               m_strobe_wr = m_req[m_w] ? m_wr[m_w] : m_wop[m_w];
               m_strobe = m_w;
               m_owner = m_w;
               m_g = m_w[0];
               m_last = m_w;
               m_wait[m_w] = 1'b0;
               if (m_req[1 - m_w]) begin
                  m_wait[1 - m_w] = 1'b1;
                  m_wop[1 - m_w]  = m_wr[1 - m_w];
               end
            end
         end else begin
            if (dev_ack | dev_err | dev_tmo) m_owner = -1;
            for (int p = 0; p < 2; p++)
               if (m_req[p]) begin m_wait[p] = 1'b1; m_wop[p] = m_wr[p]; end
         end
      end
   end

   task next();
      @(posedge clk);
      #1;
      a_rden = 1'b0; a_wren = 1'b0; b_rden = 1'b0; b_wren = 1'b0;
      dev_ack = 1'b0; dev_err = 1'b0; dev_tmo = 1'b0;
   endtask

   task do_reset();
      next();
      rstn = 1'b0;
      next();
      next();
      rstn = 1'b1;
   endtask

   // waits for the next strobe, then answers it lat (>=1) cycles later
   task automatic serve_one(input int lat, input int kind, input bit rereq,
                            output int src, output bit wr, output logic [31:0] addr);
      src = -1; wr = 1'b0; addr = '0;
      for (int i = 0; i < 12; i++) begin
         next();
         @(negedge clk);
         if (dev_rden || dev_wren) begin
            src = int'(dev_src); wr = dev_wren; addr = dev_addr;
            break;
         end
      end
      if (src < 0) return;
      repeat (lat) next();
      dev_rdata = 32'h5A5A_0000 | 32'(lat);
      dev_ack = (kind == 0); dev_err = (kind == 1); dev_tmo = (kind == 2);
      if (rereq) begin
         if (src == 0) a_rden = 1'b1;
         else          b_rden = 1'b1;
      end
      @(negedge clk);
   endtask

   task test_reset();
      next();
      dev_ack = 1'b1; a_rden = 1'b1; b_rden = 1'b1;
      @(negedge clk);
      total++;
      if ({dev_rden, dev_wren, dev_src, a_ack, a_err, a_tmo, b_ack, b_err, b_tmo} !== 9'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 000000000",
                  {dev_rden, dev_wren, dev_src, a_ack, a_err, a_tmo, b_ack, b_err, b_tmo});
      end
      next();
      rstn = 1'b1;
      @(negedge clk);
      total++;
      if ({dev_rden, dev_wren} !== 2'b00) begin
         bad++; $display("FAIL reset_no_strobe: got %b want 00", {dev_rden, dev_wren});
      end
      next();
      @(negedge clk);
      total++;
      if ({dev_rden, dev_wren} !== 2'b00) begin
         bad++; $display("FAIL reset_no_pending: got %b want 00", {dev_rden, dev_wren});
      end
   endtask

   task test_single_read();
      bit b_seen;
      int strobes;
      b_seen = 1'b0; strobes = 0;
      next();
      a_addr = 32'h8000_0010; a_rden = 1'b1;
      @(negedge clk);
      b_seen |= b_ack | b_err | b_tmo;
      total++;
      if ({dev_rden, dev_wren} !== 2'b00) begin
         bad++; $display("FAIL read_req_cycle: got %b want 00", {dev_rden, dev_wren});
      end
      next();
      @(negedge clk);
      b_seen |= b_ack | b_err | b_tmo;
      strobes += int'(dev_rden);
      total++;
      if ({dev_rden, dev_wren, dev_src} !== 3'b100 || dev_addr !== 32'h8000_0010) begin
         bad++; $display("FAIL read_strobe: got %b/%h want 100/80000010",
                         {dev_rden, dev_wren, dev_src}, dev_addr);
      end
      for (int i = 0; i < 3; i++) begin
         next();
         if (i == 2) begin dev_ack = 1'b1; dev_rdata = 32'hDEAD_BEEF; end
         @(negedge clk);
         b_seen |= b_ack | b_err | b_tmo;
         strobes += int'(dev_rden);
      end
      total++;
      if (a_ack !== 1'b1 || a_rdata !== 32'hDEAD_BEEF || b_rdata !== 32'h0) begin
         bad++; $display("FAIL read_ack: got ack=%b rdata=%h brdata=%h want 1 deadbeef 0",
                         a_ack, a_rdata, b_rdata);
      end
      next();
      @(negedge clk);
      b_seen |= b_ack | b_err | b_tmo;
      total++;
      if (a_ack !== 1'b0 || strobes != 1 || b_seen !== 1'b0) begin
         bad++; $display("FAIL read_after: got ack=%b strobes=%0d bseen=%b want 0 1 0",
                         a_ack, strobes, b_seen);
      end
   endtask

   task test_simultaneous();
      int s1, s2, s3, s4;
      bit w1, w2, w3, w4;
      logic [31:0] d1, d2, d3, d4;
      int e3, e4;
`ifdef CELLRV32_XBUS_RR_EN
      e3 = 1; e4 = 0;
`else
      e3 = 0; e4 = 1;
`endif
      do_reset();
      a_addr = 32'h1000; a_wren = 1'b1; a_wdata = 32'h1111_2222;
      b_addr = 32'h2000; b_rden = 1'b1;
      serve_one(1, 0, 1'b0, s1, w1, d1);
      serve_one(2, 0, 1'b0, s2, w2, d2);
      total++;
      if (s1 != 0 || w1 != 1'b1 || d1 !== 32'h1000 || s2 != 1 || w2 != 1'b0 || d2 !== 32'h2000) begin
         bad++; $display("FAIL simul_first_pair: got %0d/%b/%h %0d/%b/%h want 0/1/1000 1/0/2000",
                         s1, w1, d1, s2, w2, d2);
      end
      next();
      a_addr = 32'h1004; a_rden = 1'b1;
      serve_one(1, 0, 1'b0, s1, w1, d1);
      next();
      a_addr = 32'h1000; a_wren = 1'b1;
      b_addr = 32'h2000; b_rden = 1'b1;
      serve_one(1, 0, 1'b0, s3, w3, d3);
      serve_one(1, 0, 1'b0, s4, w4, d4);
      total++;
      if (s1 != 0 || s3 != e3 || s4 != e4) begin
         bad++; $display("FAIL simul_second_pair: got %0d,%0d,%0d want 0,%0d,%0d", s1, s3, s4, e3, e4);
      end
   endtask

   task test_pending_b();
      next();
      a_addr = 32'h8000_0020; a_rden = 1'b1;
      next();
      @(negedge clk);
      total++;
      if ({dev_rden, dev_src} !== 2'b10) begin
         bad++; $display("FAIL pend_a_strobe: got %b want 10", {dev_rden, dev_src});
      end
      next();
      b_addr = 32'h3000; b_rden = 1'b1;
      next();
      next();
      dev_ack = 1'b1;
      @(negedge clk);
      total++;
      if ({a_ack, b_ack} !== 2'b10) begin
         bad++; $display("FAIL pend_a_ack: got %b want 10", {a_ack, b_ack});
      end
      next();
      @(negedge clk);
      total++;
      if ({dev_rden, dev_wren} !== 2'b00) begin
         bad++; $display("FAIL pend_gap: got %b want 00", {dev_rden, dev_wren});
      end
      next();
      @(negedge clk);
      total++;
      if ({dev_rden, dev_wren, dev_src} !== 3'b101 || dev_addr !== 32'h3000) begin
         bad++; $display("FAIL pend_b_strobe: got %b/%h want 101/00003000",
                         {dev_rden, dev_wren, dev_src}, dev_addr);
      end
      next();
      dev_ack = 1'b1; dev_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      total++;
      if ({a_ack, b_ack} !== 2'b01 || b_rdata !== 32'h0BAD_F00D || a_rdata !== 32'h0) begin
         bad++; $display("FAIL pend_b_ack: got %b/%h/%h want 01/0badf00d/0", {a_ack, b_ack}, b_rdata, a_rdata);
      end
   endtask

   task test_error();
      next();
      a_addr = 32'h40; a_rden = 1'b1;
      next();
      b_addr = 32'h44; b_rden = 1'b1;
      next();
      dev_err = 1'b1;
      @(negedge clk);
      total++;
      if ({a_ack, a_err, a_tmo, b_ack, b_err, b_tmo} !== 6'b010000) begin
         bad++; $display("FAIL err_a: got %b want 010000", {a_ack, a_err, a_tmo, b_ack, b_err, b_tmo});
      end
      next();
      @(negedge clk);
      total++;
      if ({a_err, dev_rden, dev_wren} !== 3'b000) begin
         bad++; $display("FAIL err_gap: got %b want 000", {a_err, dev_rden, dev_wren});
      end
      next();
      @(negedge clk);
      total++;
      if ({dev_rden, dev_wren, dev_src} !== 3'b101 || dev_addr !== 32'h44) begin
         bad++; $display("FAIL err_b_strobe: got %b/%h want 101/00000044", {dev_rden, dev_wren, dev_src}, dev_addr);
      end
      next();
      dev_tmo = 1'b1;
      @(negedge clk);
      total++;
      if ({a_ack, a_err, a_tmo, b_ack, b_err, b_tmo} !== 6'b000001) begin
         bad++; $display("FAIL tmo_b: got %b want 000001", {a_ack, a_err, a_tmo, b_ack, b_err, b_tmo});
      end
   endtask

   task test_reset_mid();
      next();
      a_addr = 32'h600; b_addr = 32'h5000; b_rden = 1'b1;
      next();
      @(negedge clk);
      total++;
      if ({dev_rden, dev_src} !== 2'b11) begin
         bad++; $display("FAIL rmid_strobe: got %b want 11", {dev_rden, dev_src});
      end
      next();
      rstn = 1'b0;
      @(negedge clk);
      total++;
      if ({dev_rden, dev_wren, dev_src} !== 3'b000 || dev_addr !== 32'h600) begin
         bad++; $display("FAIL rmid_cleared: got %b/%h want 000/00000600", {dev_rden, dev_wren, dev_src}, dev_addr);
      end
      next();
      rstn = 1'b1;
      next();
      dev_ack = 1'b1; dev_err = 1'b1;
      @(negedge clk);
      total++;
      if ({a_ack, a_err, a_tmo, b_ack, b_err, b_tmo} !== 6'b0) begin
         bad++; $display("FAIL rmid_stray: got %b want 000000", {a_ack, a_err, a_tmo, b_ack, b_err, b_tmo});
      end
      next();
      @(negedge clk);
      total++;
      if ({dev_rden, dev_wren, dev_src} !== 3'b000) begin
         bad++; $display("FAIL rmid_idle: got %b want 000", {dev_rden, dev_wren, dev_src});
      end
   endtask

   task test_back_to_back();
      int exp_src [5];
      int s;
      bit w;
      logic [31:0] d;
`ifdef CELLRV32_XBUS_RR_EN
      exp_src = '{0, 1, 0, 1, 0};
`else
      exp_src = '{0, 0, 0, 0, 1};
`endif
      do_reset();
      a_addr = 32'hA0; b_addr = 32'hB0; a_rden = 1'b1; b_rden = 1'b1;
      for (int k = 0; k < 5; k++) begin
         serve_one(1, 0, (k < 3), s, w, d);
         total++;
         if (s != exp_src[k]) begin
            bad++; $display("FAIL b2b_grant%0d: got %0d want %0d", k, s, exp_src[k]);
         end
      end
   endtask

   task test_random();
      bit outst [2];
      int issued [2];
      int served [2];
      bit inflight, rsp_now, go, exp_rd, exp_wr;
      int cnt, r;
      logic [5:0]  exp_rsp;
      logic [31:0] exp_addr;
      outst = '{0, 0}; issued = '{0, 0}; served = '{0, 0};
      inflight = 1'b0; cnt = 0;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         next();
         rsp_now = 1'b0;
         if (m_strobe >= 0) begin inflight = 1'b1; cnt = $urandom_range(0, 3); end
         if (inflight) begin
            if (cnt == 0) begin
               inflight = 1'b0; rsp_now = 1'b1;
               r = $urandom_range(0, 2);
               dev_ack = (r == 0); dev_err = (r == 1); dev_tmo = (r == 2);
               dev_rdata = $urandom;
            end else cnt--;
         end
         for (int p = 0; p < 2; p++) begin
            go = 1'b0;
            if (rsp_now && m_owner == p) begin
               outst[p] = 1'b0;
               go = ($urandom_range(0, 3) == 0);
            end else if (!outst[p]) go = ($urandom_range(0, 2) == 0);
            if (cyc >= 540) go = 1'b0;
            if (go) begin
               r = $urandom_range(0, 2);
               outst[p] = 1'b1; issued[p]++;
               if (p == 0) begin
                  a_addr = $urandom; a_wdata = $urandom; a_ben = 4'($urandom); a_priv = 1'($urandom);
                  a_rden = (r != 1); a_wren = (r != 0);
               end else begin
                  b_addr = $urandom; b_wdata = $urandom; b_ben = 4'($urandom); b_priv = 1'($urandom);
                  b_rden = (r != 1); b_wren = (r != 0);
               end
            end
         end
         @(negedge clk);
         exp_rd = (m_strobe >= 0) && !m_strobe_wr;
         exp_wr = (m_strobe >= 0) && m_strobe_wr;
         total++;
         if ({dev_rden, dev_wren, dev_src} !== {exp_rd, exp_wr, m_g}) begin
            bad++; $display("FAIL rnd_strobe c%0d: got %b want %b", cyc,
                            {dev_rden, dev_wren, dev_src}, {exp_rd, exp_wr, m_g});
         end
         exp_addr = m_g ? b_addr : a_addr;
         total++;
         if (dev_addr !== exp_addr || dev_wdata !== (m_g ? b_wdata : a_wdata) ||
             dev_ben !== (m_g ? b_ben : a_ben) || dev_priv !== (m_g ? b_priv : a_priv)) begin
            bad++; $display("FAIL rnd_mux c%0d: got addr %h want %h", cyc, dev_addr, exp_addr);
         end
         exp_rsp = {dev_ack && m_owner == 0, dev_err && m_owner == 0, dev_tmo && m_owner == 0,
                    dev_ack && m_owner == 1, dev_err && m_owner == 1, dev_tmo && m_owner == 1};
         total++;
         if ({a_ack, a_err, a_tmo, b_ack, b_err, b_tmo} !== exp_rsp ||
             a_rdata !== (m_g ? 32'h0 : dev_rdata) || b_rdata !== (m_g ? dev_rdata : 32'h0)) begin
            bad++; $display("FAIL rnd_resp c%0d: got %b want %b", cyc,
                            {a_ack, a_err, a_tmo, b_ack, b_err, b_tmo}, exp_rsp);
         end
         if (dev_rden || dev_wren) served[dev_src]++;
      end
      total++;
      if (issued[0] != served[0] || issued[1] != served[1] || outst[0] || outst[1]) begin
         bad++; $display("FAIL rnd_drain: got served %0d/%0d want %0d/%0d", served[0], served[1],
                         issued[0], issued[1]);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_pending_b();
      test_error();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
